coproc_dbg_bridge: RTL and testbench
====================================

# coproc_dbg_bridge

Host-side debug bridge that sits directly upstream of the core's coprocessor IO port and is its only driver. It accepts single debug commands over a valid/ready channel, sequences the coprocessor address/control/data lines (memory read, register read/write, cycle breakpoint arm/clear), captures the returned data, and issues one response per command. It also tracks breakpoint-halt status for the host.

## Interface
- N, 64, data width; must match the core's N.
- READ_LAT, 1, cycles from access assertion to valid coprocessor read data (1..3).
- clk  in  1  clock.
- reset  in  1  asynchronous, active-low reset.
- cmd_valid  in  1  command offered.
- cmd_ready  out  1  bridge accepts command this cycle.
- cmd_op  in  3  0 STATUS, 1 MEM_READ, 2 REG_READ, 3 REG_WRITE, 4 SET_BREAK, 5 CLEAR_BREAK, 6/7 illegal.
- cmd_addr  in  15  coprocessor address (byte address for MEM_READ, [4:0] register index for REG_*).
- cmd_wdata  in  N  write data / breakpoint cycle value.
- rsp_valid  out  1  response available.
- rsp_ready  in  1  host accepts response.
- rsp_data  out  N  read data (0 for non-read ops).
- rsp_err  out  1  illegal op.
- rsp_halted  out  1  halted flag at capture time.
- cop_addr  out  15  to core coprocessorIOAddr.
- cop_ctrl  out  5  to core coprocessorIOControl; [0] reg read, [1] reg write, [2] reserved 0, [3] memory access, [4] breakpoint armed.
- cop_dout  out  N  to core coprocessorIODataOut.
- cop_din  in  N  from core coprocessorIODataIn.
- halted  out  1  core stopped on breakpoint.
- halt_event  out  1  one-cycle pulse on halted rising.

## Operation
- FSM states: IDLE, ACCESS, CAPTURE, RESP.
- IDLE: cmd_ready=1; cop_ctrl[3:0]=0, cop_addr=0, cop_dout=0; cop_ctrl[4]=armed. Handshake on cmd_valid&cmd_ready latches op/addr/wdata and goes to ACCESS (illegal and STATUS go straight to RESP).
- ACCESS: drive cop_addr=latched addr, cop_dout=latched wdata, cop_ctrl per op, held constant for READ_LAT cycles (down-counter), then CAPTURE.
  - MEM_READ: ctrl[3]=1. REG_READ: ctrl[0]=1. REG_WRITE: ctrl[1]=1 for exactly one cycle regardless of READ_LAT.
  - SET_BREAK: ctrl[4]=1, ctrl[3]=1, cop_addr[12]=1, cop_dout=wdata for one cycle; armed<=1.
  - CLEAR_BREAK: ctrl[4]=0 for one cycle; armed<=0 (core clears its compare register, core resumes).
- CAPTURE: rsp_data<=cop_din for MEM_READ/REG_READ, else 0; rsp_halted<=halted; ctrl returns to idle values; go to RESP.
- RESP: rsp_valid=1, outputs stable until rsp_ready; then IDLE. No new command accepted while in RESP.
- Halt detection: halted=armed & (cop_din=={0,32'hfeedc0de}) sampled only in IDLE with ctrl[3:0]=0; holds value otherwise. Cleared by CLEAR_BREAK or reset.
- While halted, core forces cop_din to 0xfeedc0de, so MEM_READ/REG_READ return that value with rsp_halted=1; this is required behaviour, not an error.
- STATUS returns rsp_data={N-2 zeros, armed, halted}.

## Timing
- Reset: state IDLE, armed=0, halted=0, halt_event=0, cop_ctrl=0, cop_addr=0, cop_dout=0, rsp_valid=0, rsp_data=0, rsp_err=0, rsp_halted=0.
- cmd accept -> rsp_valid: READ_LAT+2 cycles for reads, 3 for REG_WRITE/SET_BREAK/CLEAR_BREAK, 1 for STATUS/illegal.
- All outputs registered; no combinational path cmd_* or cop_din to cop_*.
- cop_ctrl[3:0] nonzero only in ACCESS; every access stalls the core for its duration.
- halt_event asserted in the cycle after halted rises; never while halted stays high.
- Reset mid-command: drop command, no response, ctrl to 0 (breakpoint disarmed).
- rsp_ready held low indefinitely: bridge waits in RESP, core unaffected.

## Structure
- Package coproc_dbg_pkg: op enum, cop_ctrl bit indices, COP_ADDR_BRK_BIT=12, HALT_MAGIC=32'hfeedc0de.
- Single module, one FSM plus latency counter; no sub-module.

## Test plan
- Reset release -> all outputs 0, cmd_ready=1, cop_ctrl=5'b0.
- MEM_READ addr 0x0010, model returns 0xdeadbeef after READ_LAT=1 -> ctrl=5'b01000 for 1 cycle, rsp_data=0xdeadbeef, rsp_valid 3 cycles after accept.
- REG_WRITE idx 5 data 0x1234 -> ctrl=5'b00010 exactly one cycle, cop_addr=5, cop_dout=0x1234, rsp_data=0.
- SET_BREAK 100, model drives 0xfeedc0de later -> single ctrl=5'b11000 cycle with addr[12]=1, then ctrl=5'b10000, halted=1, one halt_event pulse; STATUS returns 0x3.
- Halted MEM_READ -> rsp_data=0xfeedc0de, rsp_halted=1; CLEAR_BREAK -> ctrl[4]=0, halted=0, STATUS returns 0.
- cmd_op=6 -> rsp_err=1 next cycle; rsp_ready low 10 cycles holds response; reset asserted during ACCESS -> no response, ctrl=0.

Source files
------------

// File: rtl/coproc_dbg_pkg.sv
// Shared definitions for the coprocessor debug bridge: host command opcodes,
// bridge FSM states, coprocessor control bit positions and the halt signature.
package coproc_dbg_pkg;

  typedef enum logic [2:0] {
    OP_STATUS      = 3'd0,
    OP_MEM_READ    = 3'd1,
    OP_REG_READ    = 3'd2,
    OP_REG_WRITE   = 3'd3,
    OP_SET_BREAK   = 3'd4,
    OP_CLEAR_BREAK = 3'd5
  } copOpT;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ACCESS  = 2'd1,
    ST_CAPTURE = 2'd2,
    ST_RESP    = 2'd3
  } bridgeStateT;

  localparam int CTRL_REG_RD = 0;
  localparam int CTRL_REG_WR = 1;
  localparam int CTRL_RSVD   = 2;
  localparam int CTRL_MEM    = 3;
  localparam int CTRL_BRK    = 4;

  localparam int          COP_ADDR_BRK_BIT = 12;
  localparam logic [31:0] HALT_MAGIC       = 32'hfeedc0de;

  function automatic logic isReadOp(input logic [2:0] op);
    return (op == OP_MEM_READ) || (op == OP_REG_READ);
  endfunction

  // Ops that drive the coprocessor port; STATUS and 6/7 answer directly.
  function automatic logic isAccessOp(input logic [2:0] op);
    return (op >= OP_MEM_READ) && (op <= OP_CLEAR_BREAK);
  endfunction

endpackage

// File: rtl/coproc_dbg_bridge.sv
// Host debug bridge: turns single valid/ready commands into registered
// coprocessor IO sequences, captures read data and tracks breakpoint halt.
module coproc_dbg_bridge
  import coproc_dbg_pkg::*;
#(
  parameter int N        = 64,
  parameter int READ_LAT = 1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         cmd_valid,
  output logic         cmd_ready,
  input  logic [2:0]   cmd_op,
  input  logic [14:0]  cmd_addr,
  input  logic [N-1:0] cmd_wdata,
  output logic         rsp_valid,
  input  logic         rsp_ready,
  output logic [N-1:0] rsp_data,
  output logic         rsp_err,
  output logic         rsp_halted,
  output logic [14:0]  cop_addr,
  output logic [4:0]   cop_ctrl,
  output logic [N-1:0] cop_dout,
  input  logic [N-1:0] cop_din,
  output logic         halted,
  output logic         halt_event,
  output logic [1:0]   dbgState
);

  // Handshake: a command transfers on a cycle with cmd_valid & cmd_ready; a
  // response transfers on a cycle with rsp_valid & rsp_ready. Both sides hold
  // their payload stable while valid is high and the partner is not ready.

  localparam logic [1:0]   LAT_LOAD  = 2'(READ_LAT - 1);
  localparam logic [N-1:0] HALT_WORD = N'(HALT_MAGIC);

  bridgeStateT    state, stateNext;
  logic [1:0]     cnt, cntNext;
  logic [2:0]     opQ, opNext;
  logic [14:0]    addrQ, addrNext;
  logic [N-1:0]   wdataQ, wdataNext;
  logic           armedQ, armedNext;
  logic           haltedQ, haltedNext, haltedD, haltEventQ;
  logic [N-1:0]   rspDataQ, rspDataNext;
  logic           rspErrQ, rspErrNext, rspHaltedQ, rspHaltedNext;
  logic [4:0]     copCtrlQ, copCtrlNext;
  logic [14:0]    copAddrQ, copAddrNext;
  logic [N-1:0]   copDoutQ, copDoutNext;

  logic [2:0]     srcOp;
  logic [14:0]    srcAddr, accAddr;
  logic [N-1:0]   srcWdata;
  logic [4:0]     accCtrl;
  logic           driveAccess;

  // Access pattern for the command being launched (IDLE) or held (ACCESS).
  always_comb begin
    srcOp    = (state == ST_IDLE) ? cmd_op    : opQ;
    srcAddr  = (state == ST_IDLE) ? cmd_addr  : addrQ;
    srcWdata = (state == ST_IDLE) ? cmd_wdata : wdataQ;
    accCtrl  = '0;
    accCtrl[CTRL_BRK] = armedQ;
    accAddr  = srcAddr;
    case (srcOp)
      OP_MEM_READ:  accCtrl[CTRL_MEM]    = 1'b1;
      OP_REG_READ:  accCtrl[CTRL_REG_RD] = 1'b1;
      OP_REG_WRITE: accCtrl[CTRL_REG_WR] = 1'b1;
      OP_SET_BREAK: begin
        accCtrl[CTRL_BRK] = 1'b1;
        accCtrl[CTRL_MEM] = 1'b1;
        accAddr[COP_ADDR_BRK_BIT] = 1'b1;
      end
      OP_CLEAR_BREAK: accCtrl[CTRL_BRK] = 1'b0;
      default: ;
    endcase
  end

  always_comb begin
    stateNext     = state;
    cntNext       = cnt;
    opNext        = opQ;
    addrNext      = addrQ;
    wdataNext     = wdataQ;
    armedNext     = armedQ;
    haltedNext    = haltedQ;
    rspDataNext   = rspDataQ;
    rspErrNext    = rspErrQ;
    rspHaltedNext = rspHaltedQ;
    driveAccess   = 1'b0;
    case (state)
      ST_IDLE: begin
        // Port is quiet here, so cop_din reflects the core's halt signature.
        haltedNext = armedQ && (cop_din == HALT_WORD);
        if (cmd_valid) begin
          opNext    = cmd_op;
          addrNext  = cmd_addr;
          wdataNext = cmd_wdata;
          if (isAccessOp(cmd_op)) begin
            stateNext   = ST_ACCESS;
            driveAccess = 1'b1;
            cntNext     = isReadOp(cmd_op) ? LAT_LOAD : 2'd0;
          end else begin
            stateNext     = ST_RESP;
            rspErrNext    = (cmd_op != OP_STATUS);
            rspDataNext   = (cmd_op == OP_STATUS) ? {{(N-2){1'b0}}, armedQ, haltedQ} : '0;
            rspHaltedNext = haltedQ;
          end
        end
      end
      ST_ACCESS: begin
        if (cnt != 2'd0) begin
          cntNext     = cnt - 2'd1;
          driveAccess = 1'b1;
        end else begin
          stateNext = ST_CAPTURE;
          if (opQ == OP_SET_BREAK) armedNext = 1'b1;
          if (opQ == OP_CLEAR_BREAK) begin
            armedNext  = 1'b0;
            haltedNext = 1'b0;
          end
        end
      end
      ST_CAPTURE: begin
        rspDataNext   = isReadOp(opQ) ? cop_din : '0;
        rspErrNext    = 1'b0;
        rspHaltedNext = haltedQ;
        stateNext     = ST_RESP;
      end
      ST_RESP: begin
        if (rsp_ready) stateNext = ST_IDLE;
      end
      default: stateNext = ST_IDLE;
    endcase
    copCtrlNext = driveAccess ? accCtrl  : {armedNext, 4'b0000};
    copAddrNext = driveAccess ? accAddr  : '0;
    copDoutNext = driveAccess ? srcWdata : '0;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= ST_IDLE;
      cnt        <= '0;
      opQ        <= '0;
      addrQ      <= '0;
      wdataQ     <= '0;
      armedQ     <= 1'b0;
      haltedQ    <= 1'b0;
      haltedD    <= 1'b0;
      haltEventQ <= 1'b0;
      rspDataQ   <= '0;
      rspErrQ    <= 1'b0;
      rspHaltedQ <= 1'b0;
      copCtrlQ   <= '0;
      copAddrQ   <= '0;
      copDoutQ   <= '0;
    end else begin
      state      <= stateNext;
      cnt        <= cntNext;
      opQ        <= opNext;
      addrQ      <= addrNext;
      wdataQ     <= wdataNext;
      armedQ     <= armedNext;
      haltedQ    <= haltedNext;
      haltedD    <= haltedQ;
      haltEventQ <= haltedQ & ~haltedD;
      rspDataQ   <= rspDataNext;
      rspErrQ    <= rspErrNext;
      rspHaltedQ <= rspHaltedNext;
      copCtrlQ   <= copCtrlNext;
      copAddrQ   <= copAddrNext;
      copDoutQ   <= copDoutNext;
    end
  end

  assign cmd_ready  = (state == ST_IDLE);
  assign rsp_valid  = (state == ST_RESP);
  assign rsp_data   = rspDataQ;
  assign rsp_err    = rspErrQ;
  assign rsp_halted = rspHaltedQ;
  assign cop_ctrl   = copCtrlQ;
  assign cop_addr   = copAddrQ;
  assign cop_dout   = copDoutQ;
  assign halted     = haltedQ;
  assign halt_event = haltEventQ;
  assign dbgState   = state;

endmodule

// File: tb/tb_coproc_dbg_bridge.sv
// Bench for coproc_dbg_bridge: a small core model on the coprocessor port and
// a response scoreboard fed at command issue and drained at response accept.
module tb_coproc_dbg_bridge;

  localparam int N        = 64;
  localparam int READ_LAT = 1;
  localparam int W        = N + 2;

  localparam logic [2:0] OP_STATUS = 3'd0, OP_MEM_READ = 3'd1, OP_REG_READ = 3'd2,
                         OP_REG_WRITE = 3'd3, OP_SET_BREAK = 3'd4, OP_CLEAR_BREAK = 3'd5;
  localparam logic [N-1:0] MAGIC = 64'h0000_0000_feed_c0de;

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic         cmd_valid = 1'b0;
  logic         cmd_ready;
  logic [2:0]   cmd_op = '0;
  logic [14:0]  cmd_addr = '0;
  logic [N-1:0] cmd_wdata = '0;
  logic         rsp_valid;
  logic         rsp_ready = 1'b0;
  logic [N-1:0] rsp_data;
  logic         rsp_err, rsp_halted;
  logic [14:0]  cop_addr;
  logic [4:0]   cop_ctrl;
  logic [N-1:0] cop_dout, cop_din;
  logic         halted, halt_event;
  logic [1:0]   dbgState;

  int nChecks = 0;
  int nPass   = 0;
  logic [W-1:0] exp_q[$];

  // Core-side model state.
  logic         coreHalted = 1'b0;
  logic [N-1:0] copDinR;
  logic [N-1:0] coreRegs[32];
  logic [N-1:0] expRegs[32];

  coproc_dbg_bridge #(.N(N), .READ_LAT(READ_LAT)) dut (
    .clk(clk), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .rsp_err(rsp_err), .rsp_halted(rsp_halted),
    .cop_addr(cop_addr), .cop_ctrl(cop_ctrl), .cop_dout(cop_dout), .cop_din(cop_din),
    .halted(halted), .halt_event(halt_event), .dbgState(dbgState)
  );

  // Clock / reset block
  always #5 clk = ~clk;

  function automatic logic [N-1:0] memModel(input logic [14:0] a);
    return (a == 15'h0010) ? 64'h0000_0000_dead_beef : ({49'h0, a} ^ 64'h0000_0000_a5a5_0000);
  endfunction

  function automatic logic [W-1:0] mkRsp(input logic err, input logic hlt, input logic [N-1:0] d);
    return {err, hlt, d};
  endfunction

  // Core model: read data valid one cycle after the access is seen.
  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      copDinR <= '0;
      for (int i = 0; i < 32; i++) coreRegs[i] <= 64'h1000 + 64'(i);
    end else begin
      if (cop_ctrl[3] && !cop_ctrl[4]) copDinR <= memModel(cop_addr);
      else if (cop_ctrl == 5'b01000) copDinR <= memModel(cop_addr);
      else if (cop_ctrl[0]) copDinR <= coreRegs[cop_addr[4:0]];
      if (cop_ctrl[1]) coreRegs[cop_addr[4:0]] <= cop_dout;
    end
  end
  assign cop_din = coreHalted ? MAGIC : copDinR;

  task automatic checkVal(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    nChecks++;
    if (got === exp) nPass++;
    else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
  endtask

  // Driver: issue one command, watch the port, then drain its response.
  task automatic sendCmd(input logic [2:0] op, input logic [14:0] addr, input logic [N-1:0] wdata,
                         input logic [W-1:0] expRsp, input int expLat, input int expAcc,
                         input logic [4:0] expCtrl, input logic [14:0] expAddr,
                         input logic [N-1:0] expDout, input int hold, input string tag);
    int lat, acc;
    logic [4:0] seenCtrl;
    logic [14:0] seenAddr;
    logic [N-1:0] seenDout;
    logic [W-1:0] held, expPop;
    logic stable;
    @(negedge clk);
    checkVal({tag, "_rdy"}, W'(cmd_ready), W'(1));
    cmd_valid = 1'b1; cmd_op = op; cmd_addr = addr; cmd_wdata = wdata;
    exp_q.push_back(expRsp);
    @(posedge clk);
    #1 cmd_valid = 1'b0;
    lat = 0; acc = 0; seenCtrl = '0; seenAddr = '0; seenDout = '0;
    do begin
      @(negedge clk);
      lat++;
      if (cop_ctrl[3:0] != 4'b0) begin
        if (acc == 0) begin seenCtrl = cop_ctrl; seenAddr = cop_addr; seenDout = cop_dout; end
        acc++;
      end
    end while (!rsp_valid && lat < 20);
    checkVal({tag, "_rsp"}, W'(rsp_valid), W'(1));
    checkVal({tag, "_lat"}, W'(lat), W'(expLat));
    checkVal({tag, "_acc"}, W'(acc), W'(expAcc));
    if (expAcc > 0) begin
      checkVal({tag, "_ctrl"}, W'(seenCtrl), W'(expCtrl));
      checkVal({tag, "_addr"}, W'(seenAddr), W'(expAddr));
      checkVal({tag, "_dout"}, W'(seenDout), W'(expDout));
    end
    if (!rsp_valid) begin
      expPop = exp_q.pop_front();
      return;
    end
    held = {rsp_err, rsp_halted, rsp_data};
    stable = 1'b1;
    repeat (hold) begin
      @(negedge clk);
      if ({rsp_err, rsp_halted, rsp_data} != held || !rsp_valid || cmd_ready) stable = 1'b0;
    end
    if (hold > 0) checkVal({tag, "_hold"}, W'(stable), W'(1));
    rsp_ready = 1'b1;
    expPop = exp_q.pop_front();
    checkVal({tag, "_data"}, {rsp_err, rsp_halted, rsp_data}, expPop);
    @(posedge clk);
    #1 rsp_ready = 1'b0;
  endtask

  initial begin
    int hiAt, evAt, evCnt, idx, idx2, sawRsp;
    logic [N-1:0] d;
    for (int i = 0; i < 32; i++) expRegs[i] = 64'h1000 + 64'(i);

    repeat (3) @(negedge clk);
    checkVal("rst_cop", W'({cop_ctrl, cop_addr, cop_dout}), W'(0));
    reset = 1'b1;
    @(negedge clk);
    checkVal("rst_ready", W'(cmd_ready), W'(1));
    checkVal("rst_rsp", {rsp_valid, rsp_err, rsp_halted, rsp_data}, W'(0));
    checkVal("rst_out", W'({cop_ctrl, cop_addr, cop_dout, halted, halt_event}), W'(0));

    sendCmd(OP_MEM_READ, 15'h0010, '0, mkRsp(0, 0, 64'hdead_beef), READ_LAT + 2, READ_LAT,
            5'b01000, 15'h0010, '0, 0, "memrd");
    sendCmd(OP_REG_WRITE, 15'd5, 64'h1234, mkRsp(0, 0, '0), 3, 1,
            5'b00010, 15'd5, 64'h1234, 0, "regwr");
    expRegs[5] = 64'h1234;
    sendCmd(OP_REG_READ, 15'd5, '0, mkRsp(0, 0, 64'h1234), READ_LAT + 2, READ_LAT,
            5'b00001, 15'd5, '0, 0, "regrd");

    for (int k = 0; k < 4; k++) begin
      idx  = $urandom_range(0, 31);
      idx2 = $urandom_range(0, 31);
      d    = {$urandom, $urandom};
      sendCmd(OP_REG_WRITE, 15'(idx), d, mkRsp(0, 0, '0), 3, 1,
              5'b00010, 15'(idx), d, 0, "rndwr");
      expRegs[idx] = d;
      sendCmd(OP_REG_READ, 15'(idx2), '0, mkRsp(0, 0, expRegs[idx2]), READ_LAT + 2, READ_LAT,
              5'b00001, 15'(idx2), '0, 0, "rndrd");
    end

    sendCmd(OP_STATUS, '0, '0, mkRsp(0, 0, '0), 1, 0, '0, '0, '0, 0, "stat0");

    sendCmd(OP_SET_BREAK, '0, 64'd100, mkRsp(0, 0, '0), 3, 1,
            5'b11000, 15'h1000, 64'd100, 0, "setbrk");
    @(negedge clk);
    checkVal("armed_ctrl", W'(cop_ctrl), W'(5'b10000));
    checkVal("pre_halt", W'(halted), W'(0));

    coreHalted = 1'b1;
    hiAt = 0; evAt = 0; evCnt = 0;
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk);
      if (halted && hiAt == 0) hiAt = c;
      if (halt_event) begin evCnt++; if (evAt == 0) evAt = c; end
    end
    checkVal("halt_rise", W'(hiAt), W'(1));
    checkVal("halt_evt_at", W'(evAt), W'(2));
    checkVal("halt_evt_cnt", W'(evCnt), W'(1));

    sendCmd(OP_STATUS, '0, '0, mkRsp(0, 1, 64'h3), 1, 0, '0, '0, '0, 0, "stat3");
    sendCmd(OP_MEM_READ, 15'h0020, '0, mkRsp(0, 1, MAGIC), READ_LAT + 2, READ_LAT,
            5'b11000, 15'h0020, '0, 0, "haltrd");
    sendCmd(OP_CLEAR_BREAK, '0, '0, mkRsp(0, 0, '0), 3, 0, '0, '0, '0, 0, "clrbrk");
    coreHalted = 1'b0;
    @(negedge clk);
    checkVal("clr_state", W'({halted, cop_ctrl}), W'(0));
    sendCmd(OP_STATUS, '0, '0, mkRsp(0, 0, '0), 1, 0, '0, '0, '0, 0, "statclr");

    sendCmd(3'd6, 15'h0011, 64'h55, mkRsp(1, 0, '0), 1, 0, '0, '0, '0, 10, "ill6");
    sendCmd(3'd7, '0, '0, mkRsp(1, 0, '0), 1, 0, '0, '0, '0, 0, "ill7");

    // Reset in the middle of an access while a breakpoint is armed.
    sendCmd(OP_SET_BREAK, '0, 64'd7, mkRsp(0, 0, '0), 3, 1,
            5'b11000, 15'h1000, 64'd7, 0, "setbrk2");
    @(negedge clk);
    cmd_valid = 1'b1; cmd_op = OP_MEM_READ; cmd_addr = 15'h0030; cmd_wdata = '0;
    @(posedge clk);
    #1 cmd_valid = 1'b0;
    @(negedge clk);
    checkVal("mid_ctrl", W'(cop_ctrl), W'(5'b11000));
    reset = 1'b0;
    #1;
    checkVal("mid_rst", W'({cop_ctrl, cop_addr, rsp_valid}), W'(0));
    @(negedge clk);
    reset = 1'b1;
    sawRsp = 0;
    repeat (6) begin
      @(negedge clk);
      if (rsp_valid) sawRsp = 1;
    end
    checkVal("mid_norsp", W'(sawRsp), W'(0));
    checkVal("mid_idle", W'({cmd_ready, cop_ctrl}), W'(6'b100000));
    sendCmd(OP_STATUS, '0, '0, mkRsp(0, 0, '0), 1, 0, '0, '0, '0, 0, "statrst");

    checkVal("sb_empty", W'(exp_q.size()), W'(0));
    $display("%0d/%0d checks passed", nPass, nChecks);
    $finish;
  end

endmodule
